// File: rtl/button_event_arbiter.sv
// Button event arbiter: four debounced switches post short-press events
// (and, optionally, long-press events) that are granted round-robin into a
// small first-word-fall-through queue read by a single consumer.
// Optional feature: define LONG_PRESS_EN to build the per-switch hold
// counters and long-press events; without it i_Switch_Level is ignored and
// o_Event_Long is tied low.

module button_event_arbiter #(
  parameter int c_FIFO_DEPTH       = 4,
  parameter int c_LONG_PRESS_LIMIT = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [3:0] i_Switch_Edge,
  input  logic [3:0] i_Switch_Level,
  input  logic       i_Event_Ready,
  output logic       o_Event_Valid,
  output logic [1:0] o_Event_Id,
  output logic       o_Event_Long,
  output logic       o_Drop
);

  localparam int ADDR_W = $clog2(c_FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
`ifdef LONG_PRESS_EN
  localparam int ENTRY_W = 3;
  localparam int HOLD_W  = $clog2(c_LONG_PRESS_LIMIT + 1);
`else
  localparam int ENTRY_W = 2;
`endif

  // Request flags and arbitration state
  logic [3:0]         short_pend;
  logic [3:0]         long_pend;
  logic [3:0]         grant_short_vec;
  logic [1:0]         rr_ptr;
  logic               grant_any;
  logic [1:0]         grant_id;
  logic               grant_long;
  logic               long_drop;
  logic               drop_now;
  logic               drop;

  // Queue state
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] mem [c_FIFO_DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] push_entry;
  logic               fifo_full;
  logic               push;
  logic               pop;

  // Pick the first requesting switch at or after the round-robin pointer
  always_comb begin : grant_search
    logic [3:0] req;
    logic [1:0] idx;
    req       = short_pend | long_pend;
    idx       = rr_ptr;
    grant_any = 1'b0;
    grant_id  = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!grant_any && req[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // The push decision looks only at the count held at the start of the cycle,
  // so a pop in the same cycle never makes room for a push into a full queue.
  assign fifo_full = (count == CNT_W'(c_FIFO_DEPTH));
  assign push      = grant_any & ~fifo_full;
  assign pop       = o_Event_Valid & i_Event_Ready;

  // A switch with both flags pending is served short first.
  assign grant_short_vec = (push && !grant_long) ? (4'b0001 << grant_id) : 4'b0000;

  // A repeat edge is lost only if the earlier one is still waiting and is not
  // being taken this very cycle.
  assign drop_now = (|(i_Switch_Edge & short_pend & ~grant_short_vec)) | long_drop;

`ifdef LONG_PRESS_EN
  logic [HOLD_W-1:0] hold_cnt [4];
  logic [3:0]        long_hit;
  logic [3:0]        grant_long_vec;

  assign grant_long     = push & ~short_pend[grant_id];
  assign grant_long_vec = grant_long ? (4'b0001 << grant_id) : 4'b0000;
  assign long_drop      = |(long_hit & long_pend & ~grant_long_vec);
  assign push_entry     = {grant_long, grant_id};

  // Flag the cycle in which a held switch reaches the long-press threshold
  always_comb begin
    long_hit = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      long_hit[n] = i_Switch_Level[n] &&
                    (hold_cnt[n] == HOLD_W'(c_LONG_PRESS_LIMIT - 1));
    end
  end

  // Hold counters saturate at the threshold and re-arm only after release
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int n = 0; n < 4; n++) begin
        hold_cnt[n] <= '0;
      end
      long_pend <= 4'b0000;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (!i_Switch_Level[n]) begin
          hold_cnt[n] <= '0;
        end else if (hold_cnt[n] != HOLD_W'(c_LONG_PRESS_LIMIT)) begin
          hold_cnt[n] <= hold_cnt[n] + 1'b1;
        end
      end
      long_pend <= (long_pend & ~grant_long_vec) | long_hit;
    end
  end

  assign o_Event_Long = o_Event_Valid & head[2];
`else
  logic unused_level;

  assign unused_level = ^i_Switch_Level;
  assign long_pend    = 4'b0000;
  assign grant_long   = 1'b0;
  assign long_drop    = 1'b0;
  assign push_entry   = grant_id;
  assign o_Event_Long = 1'b0;
`endif

  // Short flags: a new edge always wins over the clear from a grant
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      short_pend <= 4'b0000;
      drop       <= 1'b0;
    end else begin
      short_pend <= (short_pend & ~grant_short_vec) | i_Switch_Edge;
      drop       <= drop_now;
    end
  end

  // Round-robin pointer holds on a switch whose long event still waits
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rr_ptr <= 2'd0;
    end else if (push) begin
      if (!grant_long && long_pend[grant_id]) begin
        rr_ptr <= grant_id;
      end else begin
        rr_ptr <= grant_id + 2'd1;
      end
    end
  end

  // Queue pointers wrap naturally because the depth is a power of two
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; the cleared count hides stale entries
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head          = mem[rd_ptr];
  assign o_Event_Valid = (count != '0);
  assign o_Event_Id    = o_Event_Valid ? head[1:0] : 2'b00;
  assign o_Drop        = drop;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed vectors with
// hand-computed expectations plus an event-queue model compared every cycle.
// Honours LONG_PRESS_EN the same way as the design.

module tb_button_event_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_edge;
  logic [3:0] sw_level;
  logic       ready;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic       ev_long;
  logic       drop;

  int checks = 0;
  int errors = 0;

  button_event_arbiter #(
    .c_FIFO_DEPTH      (DEPTH),
    .c_LONG_PRESS_LIMIT(LIMIT)
  ) dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Switch_Edge (sw_edge),
    .i_Switch_Level(sw_level),
    .i_Event_Ready (ready),
    .o_Event_Valid (ev_valid),
    .o_Event_Id    (ev_id),
    .o_Event_Long  (ev_long),
    .o_Drop        (drop)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Model: pending flags per switch, a queue of events, and a drop flag
  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } ev_t;

  ev_t mq[$];
  bit  m_short[4];
  bit  m_long[4];
  int  m_ptr;
  bit  m_drop;
`ifdef LONG_PRESS_EN
  int  m_cnt[4];
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] e, input logic [3:0] l, input logic r);
    @(negedge clk);
    sw_edge  = e;
    sw_level = l;
    ready    = r;
  endtask

  function automatic void modelClear();
    mq.delete();
    for (int n = 0; n < 4; n++) begin
      m_short[n] = 1'b0;
      m_long[n]  = 1'b0;
`ifdef LONG_PRESS_EN
      m_cnt[n]   = 0;
`endif
    end
    m_ptr  = 0;
    m_drop = 1'b0;
  endfunction

  function automatic void modelStep();
    bit  pre_s[4];
    bit  pre_l[4];
    bit  gs[4];
    int  g;
    ev_t ev;
`ifdef LONG_PRESS_EN
    bit  gl[4];
`endif
    g = -1;
    for (int n = 0; n < 4; n++) begin
      pre_s[n] = m_short[n];
      pre_l[n] = m_long[n];
      gs[n]    = 1'b0;
`ifdef LONG_PRESS_EN
      gl[n]    = 1'b0;
`endif
    end
    if (mq.size() < DEPTH) begin
      for (int k = 0; k < 4; k++) begin
        int n;
        n = (m_ptr + k) % 4;
        if (g < 0 && (pre_s[n] || pre_l[n])) g = n;
      end
    end
    if (mq.size() > 0 && ready) void'(mq.pop_front());
    if (g >= 0) begin
      ev.id = 2'(g);
      if (pre_s[g]) begin
        gs[g]      = 1'b1;
        m_short[g] = 1'b0;
        ev.lng     = 1'b0;
        m_ptr      = pre_l[g] ? g : (g + 1) % 4;
      end else begin
`ifdef LONG_PRESS_EN
        gl[g]      = 1'b1;
`endif
        m_long[g]  = 1'b0;
        ev.lng     = 1'b1;
        m_ptr      = (g + 1) % 4;
      end
      mq.push_back(ev);
    end
    m_drop = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (sw_edge[n]) begin
        if (pre_s[n] && !gs[n]) m_drop = 1'b1;
        m_short[n] = 1'b1;
      end
`ifdef LONG_PRESS_EN
      if (sw_level[n]) begin
        if (m_cnt[n] < LIMIT) begin
          m_cnt[n]++;
          if (m_cnt[n] == LIMIT) begin
            if (pre_l[n] && !gl[n]) m_drop = 1'b1;
            m_long[n] = 1'b1;
          end
        end
      end else begin
        m_cnt[n] = 0;
      end
`endif
    end
  endfunction

  // Advance the model on every clock edge, or clear it on reset
  always @(posedge clk or posedge rst) begin
    if (rst) modelClear();
    else     modelStep();
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    checkOutput("cmp_valid", 32'(ev_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      checkOutput("cmp_id", 32'(ev_id), 32'(mq[0].id));
      checkOutput("cmp_long", 32'(ev_long), 32'(mq[0].lng));
    end
    checkOutput("cmp_drop", 32'(drop), 32'(m_drop));
  end

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    sw_edge  = 4'b0000;
    sw_level = 4'b0000;
    ready    = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(ev_valid), 32'd0);
    checkOutput("rst_id", 32'(ev_id), 32'd0);
    checkOutput("rst_long", 32'(ev_long), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    sw_edge  = 4'b0000;
    sw_level = 4'b0000;
    ready    = 1'b0;

    // Single pulse on switch 2
    doReset();
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("single_valid_early", 32'(ev_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("single_valid", 32'(ev_valid), 32'd1);
    checkOutput("single_id", 32'(ev_id), 32'd2);
    checkOutput("single_long", 32'(ev_long), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("single_gone", 32'(ev_valid), 32'd0);

    // All four at once, then switch 1 followed by switch 0
    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("rr_valid", 32'(ev_valid), 32'd1);
      checkOutput("rr_id", 32'(ev_id), 32'(i));
    end
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    checkOutput("rr_empty", 32'(ev_valid), 32'd0);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("rr_id_1", 32'(ev_id), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("rr_id_0", 32'(ev_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("rr_drained", 32'(ev_valid), 32'd0);

    // Backpressure with two coalesced repeats on switch 3
    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("bp_drop_1", 32'(drop), 32'd1);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    checkOutput("bp_drop_gap", 32'(drop), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("bp_drop_2", 32'(drop), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("bp_drop_end", 32'(drop), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("bp_count_full", 32'(dut.count), 32'd4);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("bp_head_0", 32'(ev_id), 32'd0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("bp_drain_id", 32'(ev_id), 32'(i));
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("bp_empty", 32'(ev_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("bp_stays_empty", 32'(ev_valid), 32'd0);

    // Full boundary: pop while full blocks the push for one cycle
    doReset();
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_count_a", 32'(dut.count), 32'd4);
    checkOutput("full_head", 32'(ev_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("full_count_b", 32'(dut.count), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_count_c", 32'(dut.count), 32'd4);
    checkOutput("full_head_1", 32'(ev_id), 32'd1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_head_2", 32'(ev_id), 32'd2);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_head_3", 32'(ev_id), 32'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_head_late0", 32'(ev_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("full_empty", 32'(ev_valid), 32'd0);

    // Asynchronous reset with three events queued
    doReset();
    applyStimulus(4'b0111, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0000, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    checkOutput("mid_valid_before", 32'(ev_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_valid_async", 32'(ev_valid), 32'd0);
    checkOutput("mid_id_async", 32'(ev_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("mid_no_stale", 32'(ev_valid), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("mid_first_valid", 32'(ev_valid), 32'd1);
    checkOutput("mid_first_id", 32'(ev_id), 32'd2);

    // Long press on switch 3: level high for 15 cycles
    doReset();
    applyStimulus(4'b1000, 4'b1000, 1'b1);
    for (int i = 1; i < 15; i++) begin
      applyStimulus(4'b0000, 4'b1000, 1'b1);
      if (i == 2) begin
        checkOutput("lp_short_valid", 32'(ev_valid), 32'd1);
        checkOutput("lp_short_id", 32'(ev_id), 32'd3);
        checkOutput("lp_short_long", 32'(ev_long), 32'd0);
      end
      if (i == 11) begin
`ifdef LONG_PRESS_EN
        checkOutput("lp_long_valid", 32'(ev_valid), 32'd1);
        checkOutput("lp_long_id", 32'(ev_id), 32'd3);
        checkOutput("lp_long_flag", 32'(ev_long), 32'd1);
`else
        checkOutput("lp_none_valid", 32'(ev_valid), 32'd0);
`endif
      end
      if (i == 12) checkOutput("lp_after", 32'(ev_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("lp_quiet", 32'(ev_valid), 32'd0);

    // Mixed traffic with a held switch and intermittent readiness
    doReset();
    for (int i = 0; i < 30; i++) begin
      applyStimulus((i % 3 == 0) ? 4'b0010 : ((i % 5 == 0) ? 4'b1001 : 4'b0000),
                    (i < 14) ? 4'b0010 : 4'b0000,
                    (i >= 8) && (i % 2 == 0));
    end
    for (int i = 0; i < 8; i++) applyStimulus(4'b0000, 4'b0000, 1'b1);
    checkOutput("mix_drained", 32'(ev_valid), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter c_FIFO_DEPTH, default 4, number of event queue entries (power of 2, 2..16).
REQ-002 Parameter c_LONG_PRESS_LIMIT, default 12500000, clock cycles of continuous press that qualify a long press (0.5 s at 25 MHz).
REQ-003 Port i_Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 Port i_Switch_Edge  input  4  one-cycle rising-edge pulses from four debounced switches; bit n is switch n.
REQ-006 Port i_Switch_Level  input  4  debounced stable switch levels.
REQ-007 Port i_Event_Ready  input  1  consumer accepts the head event this cycle.
REQ-008 Port o_Event_Valid  output  1  queue non-empty; head event presented.
REQ-009 Port o_Event_Id  output  2  switch index of the head event.
REQ-010 Port o_Event_Long  output  1  head event is a long press.
REQ-011 Port o_Drop  output  1  one-cycle pulse: an event was lost to coalescing.

Function
REQ-012 Per switch n, a short-pending flag SHALL set on a rising clock edge where i_Switch_Edge[n]=1.
REQ-013 An edge arriving while short-pending[n] is already set and not granted that cycle SHALL be coalesced, and o_Drop SHALL pulse on the next cycle.
REQ-014 Each cycle with FIFO count < c_FIFO_DEPTH at cycle start and at least one pending flag set, the arbiter SHALL grant exactly one request and push it into the FIFO.
REQ-015 Grant order SHALL be round-robin over switch index, searching upward from (last granted index + 1) mod 4, wrapping 3 to 0; the pointer SHALL be 0 after reset.
REQ-016 If one switch has both short and long flags pending, short SHALL be granted first; the pointer SHALL NOT advance until that switch's long flag is also granted.
REQ-017 A granted flag SHALL clear on the grant edge, unless a new edge for the same switch arrives in that cycle, in which case it SHALL remain set with no o_Drop.
REQ-018 The FIFO SHALL be first-word-fall-through: o_Event_Valid=1 iff count>0, and o_Event_Id/o_Event_Long SHALL show the head entry.
REQ-019 A pop SHALL occur on a rising edge where o_Event_Valid=1 and i_Event_Ready=1; i_Event_Ready while empty SHALL be ignored.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; a push SHALL be blocked when count=c_FIFO_DEPTH at cycle start, even if a pop occurs that cycle.
REQ-021 While the FIFO is full, pending flags SHALL persist with no event loss; only REQ-013 coalescing loses events.
REQ-022 Latency: with an empty FIFO and no other pending flags, o_Event_Valid SHALL rise 2 rising edges after the edge that samples i_Switch_Edge[n]=1.
REQ-023 Read and write pointers SHALL wrap modulo c_FIFO_DEPTH; count SHALL be log2(c_FIFO_DEPTH)+1 bits wide.

Reset
REQ-024 While i_Rst=1, these SHALL be held at 0 immediately, independent of i_Clk: all pending flags, long counters, FIFO pointers and count, round-robin pointer, o_Event_Valid, o_Event_Id, o_Event_Long and o_Drop.
REQ-025 FIFO contents asserted mid-operation SHALL be discarded by reset; the first cycle after deassertion SHALL behave as post-power-up.

Configuration
REQ-026 Macro LONG_PRESS_EN: when defined, each switch SHALL have a counter that increments while i_Switch_Level[n]=1 and clears when it is 0.
REQ-027 With LONG_PRESS_EN defined, reaching c_LONG_PRESS_LIMIT SHALL set long-pending[n] once; the counter SHALL saturate and SHALL NOT re-arm until the level returns to 0.
REQ-028 With LONG_PRESS_EN defined, a long event SHALL be queued with o_Event_Long=1.
REQ-029 With LONG_PRESS_EN undefined: no counters or long flags SHALL exist, i_Switch_Level SHALL be unused, and o_Event_Long SHALL be constant 0.

Verification
REQ-030 Single pulse: i_Switch_Edge=4'b0100 for one cycle, ready=1 -> o_Event_Valid high 2 edges later with Id=2, Long=0, for one cycle.
REQ-031 Simultaneous pulses: i_Switch_Edge=4'b1111, ready=1 -> Ids 0,1,2,3 on consecutive cycles; next lone pulse on 1 then 0 -> order 1,0 per pointer.
REQ-032 Backpressure: ready=0 with 6 events on 4 distinct switches (2 repeats while pending) -> FIFO holds 4, o_Drop pulses twice; ready=1 -> 4 events drain, no further output.
REQ-033 Full boundary: FIFO full, pending set, pop with ready=1 in cycle k -> no push in k; push in k+1; count sequence 4,3,4.
REQ-034 Reset mid-stream: 3 queued entries, i_Rst pulsed asynchronously between edges -> o_Event_Valid=0 immediately; first event after release is Id of the next new pulse.
REQ-035 LONG_PRESS_EN with c_LONG_PRESS_LIMIT=10: edge plus level high 15 cycles on switch 3 -> short Id=3, then exactly one long Id=3 Long=1; with the macro undefined, only the short event.
